splitter_pulse_sched: RTL

- Clocked scheduler that shares one SFQ splitter cell among NREQ requesters.
- Issues toggle-encoded pulses (one edge equals one SFQ pulse) on the splitter input, round-robin.
- Enforces the splitter's critical-timing holdoff in clock cycles, and checks that both splitter outputs toggle back within a timeout window.
- Sits between requesting logic and the splitter's digital model; spl_out1/spl_out2 are already synchronous to clk.

---
 rtl/splitter_pulse_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/splitter_pulse_sched.sv
// Round-robin scheduler sharing one SFQ splitter cell among NREQ requesters.
// Issues toggle-encoded pulses, enforces critical-timing holdoff and checks both output returns.
module splitter_pulse_sched #(
    parameter int NREQ    = 4,
    parameter int CT_CYC  = 5,
    parameter int TMO_CYC = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             spl_in,
    input  logic             spl_out1,
    input  logic             spl_out2,
    output logic             busy,
    input  logic             err_clr,
    output logic             tmo_err,
    output logic             spur_err,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = $clog2(TMO_CYC + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CW-1:0]    cnt;
    logic             prev1;
    logic             prev2;
    logic             seen1;
    logic             seen2;

    logic             ev1;
    logic             ev2;
    logic             seen1_n;
    logic             seen2_n;
    logic [NREQ-1:0]  hi_req;
    logic [NREQ-1:0]  win_oh;
    logic [PTR_W-1:0] win_idx;

    // Bits strictly above the last winner get first pick on the next grant.
    function automatic logic [NREQ-1:0] above_mask(input logic [PTR_W-1:0] ptr);
        logic [NREQ-1:0] m;
        m = '0;
        for (int i = 0; i < NREQ; i++) begin
            m[i] = (i > int'(ptr));
        end
        return m;
    endfunction

    function automatic logic [NREQ-1:0] lowest_set(input logic [NREQ-1:0] x);
        return x & (~x + NREQ'(1));
    endfunction

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

    assign ev1     = spl_out1 ^ prev1;
    assign ev2     = spl_out2 ^ prev2;
    assign seen1_n = seen1 | ev1;
    assign seen2_n = seen2 | ev2;

    always_comb begin
        hi_req  = req & above_mask(rr_ptr);
        win_oh  = (hi_req != '0) ? lowest_set(hi_req) : lowest_set(req);
        win_idx = oh_to_idx(win_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= PTR_W'(NREQ - 1);
            cnt       <= '0;
            prev1     <= 1'b0;
            prev2     <= 1'b0;
            seen1     <= 1'b0;
            seen2     <= 1'b0;
            gnt       <= '0;
            spl_in    <= 1'b0;
            busy      <= 1'b0;
            tmo_err   <= 1'b0;
            spur_err  <= 1'b0;
            issue_cnt <= '0;
        end else begin
            prev1 <= spl_out1;
            prev2 <= spl_out2;
            gnt   <= '0;
            // Clear first so that any set below in the same cycle takes precedence.
            if (err_clr) begin
                tmo_err  <= 1'b0;
                spur_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ev1 || ev2) begin
                        spur_err <= 1'b1;
                    end
                    if (req != '0) begin
                        gnt       <= win_oh;
                        spl_in    <= ~spl_in;
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        rr_ptr    <= win_idx;
                        cnt       <= CW'(1);
                        seen1     <= 1'b0;
                        seen2     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt   <= cnt + CW'(1);
                    seen1 <= seen1_n;
                    seen2 <= seen2_n;
                    if ((ev1 && seen1) || (ev2 && seen2)) begin
                        spur_err <= 1'b1;
                    end
                    if (seen1_n && seen2_n && (cnt >= CW'(CT_CYC))) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CW'(TMO_CYC)) begin
                        tmo_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
